// File: rtl/gcm_rx_pkg.sv
// Shared types and default widths for the GCM receive-side tag checker.
package gcm_rx_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int META_W_DEF  = 289;
    localparam int DEPTH_DEF   = 64;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISCARD  = 3'd2,
        WAIT_TAG = 3'd3,
        RELEASE  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/gcm_rx_buffer.sv
// Payload store: simple dual-port RAM with synchronous write and a registered,
// read-enabled output so the released word holds while downstream stalls.
module gcm_rx_buffer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gcm_rx_tag_checker.sv
// Store-and-forward receive tag checker: buffers a packet, compares its trailing
// tag with the decrypt core's tag, then releases the payload or drops it whole.
module gcm_rx_tag_checker
    import gcm_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int META_W  = META_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              o_in_ready,
    input  logic              i_new,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    input  logic [META_W-1:0] i_meta,
    input  logic              i_tag_valid,
    input  logic [DATA_W-1:0] i_calc_tag,
    output logic              o_valid,
    input  logic              i_out_ready,
    output logic              o_new,
    output logic              o_last,
    output logic [DATA_W-1:0] o_data,
    output logic [META_W-1:0] o_meta,
    output logic              o_pass,
    output logic              o_drop
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    rx_state_t         r_state, w_next_state;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic [CW-1:0]     r_rd_ptr;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_tag, r_calc, w_cmp_tag;
    logic [META_W-1:0] r_meta;
    logic              r_pending, r_pass, r_drop;
    logic              r_out_valid, r_out_new, r_out_last;
    logic              w_in_ready, w_acc, w_wr_en, w_meta_cap, w_tag_cap;
    logic              w_pass, w_drop, w_clr_pending, w_tag_set, w_tag_avail;
    logic              w_rd_en, w_last_hs;
    logic [AW-1:0]     w_wr_addr;
    logic [DATA_W-1:0] w_rd_data;

    assign w_in_ready  = !reset && (r_state == IDLE || r_state == COLLECT || r_state == DISCARD);
    assign w_acc       = i_valid && w_in_ready;
    assign w_tag_set   = i_tag_valid && (r_state == COLLECT || r_state == WAIT_TAG);
    assign w_tag_avail = r_pending || i_tag_valid;
    assign w_cmp_tag   = i_tag_valid ? i_calc_tag : r_calc;
    assign w_last_hs   = r_out_valid && i_out_ready && r_out_last;

    // A new-packet word restarts collection from any accepting state, dropping
    // whatever was partially collected.
    always_comb begin
        w_next_state  = r_state;
        w_count_nxt   = r_count;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_count[AW-1:0];
        w_meta_cap    = 1'b0;
        w_tag_cap     = 1'b0;
        w_pass        = 1'b0;
        w_drop        = 1'b0;
        w_clr_pending = 1'b0;
        if (w_acc && i_new) begin
            w_drop        = (r_state != IDLE);
            w_clr_pending = 1'b1;
            if (i_last) begin
                w_drop       = 1'b1;
                w_count_nxt  = '0;
                w_next_state = IDLE;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_addr    = '0;
                w_meta_cap   = 1'b1;
                w_count_nxt  = CW'(1);
                w_next_state = COLLECT;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_acc) begin
                        if (i_last) begin
                            w_tag_cap    = 1'b1;
                            w_next_state = WAIT_TAG;
                        end else if (r_count == CW'(DEPTH)) begin
                            w_next_state = DISCARD;
                        end else begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = r_count + CW'(1);
                        end
                    end
                end
                DISCARD: begin
                    if (w_acc && i_last) begin
                        w_drop        = 1'b1;
                        w_clr_pending = 1'b1;
                        w_count_nxt   = '0;
                        w_next_state  = IDLE;
                    end
                end
                WAIT_TAG: begin
                    if (w_tag_avail) begin
                        w_clr_pending = 1'b1;
                        if (w_cmp_tag == r_tag) begin
                            w_pass       = 1'b1;
                            w_next_state = RELEASE;
                        end else begin
                            w_drop       = 1'b1;
                            w_count_nxt  = '0;
                            w_next_state = IDLE;
                        end
                    end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                        w_drop        = 1'b1;
                        w_clr_pending = 1'b1;
                        w_count_nxt   = '0;
                        w_next_state  = IDLE;
                    end
                end
                RELEASE: begin
                    if (w_last_hs) begin
                        w_count_nxt  = '0;
                        w_next_state = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_to_cnt  <= '0;
            r_tag     <= '0;
            r_calc    <= '0;
            r_meta    <= '0;
            r_pending <= 1'b0;
            r_pass    <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_count  <= w_count_nxt;
            r_pass   <= w_pass;
            r_drop   <= w_drop;
            r_to_cnt <= (r_state == WAIT_TAG) ? r_to_cnt + TO_W'(1) : '0;
            if (w_tag_cap)  r_tag  <= i_data;
            if (w_meta_cap) r_meta <= i_meta;
            if (w_tag_set)  r_calc <= i_calc_tag;
            if (w_clr_pending) begin
                r_pending <= 1'b0;
            end else if (w_tag_set) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Prefetch: fetch the next word whenever the output register is empty or
    // being consumed this cycle, so a continuously ready sink sees no bubbles.
    assign w_rd_en = (r_state == RELEASE) && (r_rd_ptr < r_count) && (!r_out_valid || i_out_ready);

    always_ff @(posedge clk) begin
        if (reset || r_state != RELEASE) begin
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_new   <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_ptr    <= r_rd_ptr + CW'(1);
            r_out_valid <= 1'b1;
            r_out_new   <= (r_rd_ptr == '0);
            r_out_last  <= (r_rd_ptr == r_count - CW'(1));
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_new   <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    gcm_rx_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign o_in_ready = w_in_ready;
    assign o_valid    = r_out_valid;
    assign o_new      = r_out_new;
    assign o_last     = r_out_last;
    assign o_data     = w_rd_data;
    assign o_meta     = r_meta;
    assign o_pass     = r_pass;
    assign o_drop     = r_drop;

endmodule

// File: tb/tb_gcm_rx_tag_checker.sv
// Self-checking bench for gcm_rx_tag_checker: directed scenarios plus random
// packets scored against a packet-level reference model.
module tb_gcm_rx_tag_checker;

    localparam int DATA_W  = 128;
    localparam int META_W  = 289;
    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_valid, i_new, i_last, i_tag_valid, i_out_ready;
    logic [DATA_W-1:0] i_data, i_calc_tag;
    logic [META_W-1:0] i_meta;
    logic              o_in_ready, o_valid, o_new, o_last, o_pass, o_drop;
    logic [DATA_W-1:0] o_data;
    logic [META_W-1:0] o_meta;

    gcm_rx_tag_checker #(
        .DATA_W (DATA_W), .META_W (META_W), .DEPTH (DEPTH), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset (reset), .i_valid (i_valid), .o_in_ready (o_in_ready),
        .i_new (i_new), .i_last (i_last), .i_data (i_data), .i_meta (i_meta),
        .i_tag_valid (i_tag_valid), .i_calc_tag (i_calc_tag), .o_valid (o_valid),
        .i_out_ready (i_out_ready), .o_new (o_new), .o_last (o_last), .o_data (o_data),
        .o_meta (o_meta), .o_pass (o_pass), .o_drop (o_drop)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state
    logic [DATA_W+1:0] exp_q[$];  // {new, last, data}
    logic [META_W-1:0] exp_meta;
    int n_cmp = 0, n_err = 0;
    int exp_npass = 0, exp_ndrop = 0;
    int n_pass = 0, n_drop = 0, n_hs = 0;
    int pass_cyc = -1, drop_cyc = -1, first_valid_cyc = -1, hs_cyc = -1;
    logic rdy_random = 1'b0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (rdy_random) begin
            #1;
            i_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pulses, and every presented output word against the model queue
    always @(negedge clk) begin
        if (!reset) begin
            if (o_pass) begin n_pass++; pass_cyc = cyc; end
            if (o_drop) begin n_drop++; drop_cyc = cyc; end
            if (o_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", o_valid, 0);
                end else begin
                    check_eq("out_word", {o_new, o_last, o_data}, exp_q[0]);
                    if (i_out_ready) begin
                        check_eq("out_meta", o_meta, exp_meta);
                        void'(exp_q.pop_front());
                        n_hs++;
                        hs_cyc = cyc;
                    end
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [META_W-1:0] rand_meta();
        logic [META_W-1:0] m = '0;
        for (int i = 0; i < 10; i++) m = {m[META_W-33:0], $urandom()};
        return m;
    endfunction

    // driver tasks
    task automatic send_word(input logic nw, input logic lst, input logic [DATA_W-1:0] d,
                             input logic [META_W-1:0] m, input logic tv, input logic [DATA_W-1:0] ct);
        bit done = 0;
        i_valid = 1'b1; i_new = nw; i_last = lst; i_data = d; i_meta = m;
        i_tag_valid = tv; i_calc_tag = ct;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (o_in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) check_eq("in_ready_wait", o_in_ready, 1);
        i_valid = 1'b0; i_new = 1'b0; i_last = 1'b0; i_tag_valid = 1'b0;
    endtask

    // tag_mode 0: calc tag with payload word tag_pos (1..len, len = on the tag word)
    // tag_mode 1: calc tag tag_pos cycles into WAIT_TAG; tag_mode 2: never
    task automatic send_packet(input int len, input logic [DATA_W-1:0] tag, input logic [DATA_W-1:0] calc,
                               input int tag_mode, input int tag_pos, output int t0);
        logic [DATA_W-1:0] words[$];
        logic [META_W-1:0] m = rand_meta();
        bit arrives, pass;
        for (int j = 0; j < len; j++) words.push_back(rand_word());
        arrives = (tag_mode == 0) || (tag_mode == 1 && tag_pos <= TIMEOUT - 1);
        pass = (len <= DEPTH) && arrives && (calc == tag);
        if (pass) begin
            exp_npass++;
            exp_meta = m;
            for (int j = 0; j < len; j++) exp_q.push_back({j == 0, j == len - 1, words[j]});
        end else begin
            exp_ndrop++;
        end
        first_valid_cyc = -1;
        for (int j = 0; j < len; j++)
            send_word(j == 0, 1'b0, words[j], m, tag_mode == 0 && tag_pos == j, calc);
        send_word(1'b0, 1'b1, tag, m, tag_mode == 0 && tag_pos == len, calc);
        t0 = cyc;
        if (tag_mode == 1) begin
            repeat (tag_pos) @(posedge clk);
            #1;
            i_tag_valid = 1'b1; i_calc_tag = calc;
            @(posedge clk);
            #1;
            i_tag_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            @(posedge clk);
            #1;
            if (o_in_ready && !o_valid) done = 1;
        end
        if (!done) check_eq("wait_idle", o_in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_npass"}, n_pass, exp_npass);
        check_eq({tag, "_ndrop"}, n_drop, exp_ndrop);
        check_eq({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, hs0, np, nd;
        logic [DATA_W-1:0] tag;
        reset = 1'b1; i_valid = 0; i_new = 0; i_last = 0; i_tag_valid = 0;
        i_data = '0; i_meta = '0; i_calc_tag = '0; i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", o_in_ready, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_pulses", {o_pass, o_drop, o_new, o_last}, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_meta", o_meta, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_in_ready", o_in_ready, 1);

        // good 3-word packet, calc tag during collect, continuous ready
        tag = rand_word();
        send_packet(3, tag, tag, 0, 1, t0);
        wait_idle(50);
        check_eq("t1_pass_cyc", pass_cyc, t0 + 1);
        check_eq("t1_first_valid", first_valid_cyc, t0 + 2);
        check_eq("t1_back_to_back", hs_cyc - first_valid_cyc, 2);
        check_counts("t1");

        // wrong tag arriving 5 cycles into WAIT_TAG
        hs0 = n_hs;
        tag = rand_word();
        send_packet(3, tag, tag ^ 128'd1, 1, 5, t0);
        check_eq("t2_drop_now", o_drop, 1);
        check_eq("t2_in_ready", o_in_ready, 1);
        wait_idle(50);
        check_eq("t2_drop_cyc", drop_cyc, t0 + 6);
        check_eq("t2_no_output", n_hs - hs0, 0);
        check_counts("t2");

        // oversize packet -> discard, then a good packet
        hs0 = n_hs;
        tag = rand_word();
        send_packet(DEPTH + 2, tag, tag, 0, 1, t0);
        wait_idle(50);
        check_eq("t3_drop_cyc", drop_cyc, t0);
        check_eq("t3_no_output", n_hs - hs0, 0);
        check_counts("t3a");
        send_packet(4, tag, tag, 0, 4, t0);
        wait_idle(50);
        check_eq("t3_after_pass_cyc", pass_cyc, t0 + 1);
        check_counts("t3b");

        // no calc tag at all -> timeout drop
        send_packet(4, rand_word(), rand_word(), 2, 0, t0);
        wait_idle(TIMEOUT + 50);
        check_eq("t4_timeout_cyc", drop_cyc, t0 + TIMEOUT);
        check_counts("t4");

        // 2-word pass with ready 1,0,0,1
        hs0 = n_hs;
        i_out_ready = 1'b0;
        tag = rand_word();
        send_packet(2, tag, tag, 0, 2, t0);
        for (int k = 0; k < 20 && !o_valid; k++) begin @(posedge clk); #1; end
        check_eq("t5_valid_seen", o_valid, 1);
        i_out_ready = 1'b1; @(posedge clk); #1;
        i_out_ready = 1'b0; @(posedge clk); #1;
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        wait_idle(50);
        check_eq("t5_handshakes", n_hs - hs0, 2);
        check_counts("t5");

        // stray word, malformed new+last, then new packet mid-collect
        send_word(1'b0, 1'b0, rand_word(), rand_meta(), 1'b0, '0);
        send_word(1'b1, 1'b1, rand_word(), rand_meta(), 1'b0, '0);
        exp_ndrop++;
        send_word(1'b1, 1'b0, rand_word(), rand_meta(), 1'b0, '0);
        send_word(1'b0, 1'b0, rand_word(), rand_meta(), 1'b0, '0);
        exp_ndrop++;
        tag = rand_word();
        send_packet(3, tag, tag, 0, 2, t0);
        wait_idle(50);
        check_counts("t6");

        // reset while releasing
        i_out_ready = 1'b0;
        tag = rand_word();
        send_packet(3, tag, tag, 0, 2, t0);
        for (int k = 0; k < 20 && !o_valid; k++) begin @(posedge clk); #1; end
        check_eq("t7_valid_seen", o_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t7_valid_cleared", o_valid, 0);
        check_eq("t7_no_pulses", {o_pass, o_drop}, 0);
        exp_q.delete();
        np = n_pass; nd = n_drop;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t7_pulses_after", {n_pass - np, n_drop - nd}, 0);
        check_eq("t7_in_ready", o_in_ready, 1);
        check_counts("t7");

        // random packets, random downstream ready
        rdy_random = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len, mode, pos;
            logic [DATA_W-1:0] calc;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 2) : $urandom_range(1, 8);
            tag = rand_word();
            calc = ($urandom_range(0, 2) == 0) ? tag ^ (128'd1 << $urandom_range(0, DATA_W - 1)) : tag;
            mode = $urandom_range(0, 1);
            pos = (mode == 0) ? $urandom_range(1, len) : $urandom_range(0, 20);
            if ($urandom_range(0, 7) == 0) send_word(1'b0, 1'b0, rand_word(), rand_meta(), 1'b0, '0);
            send_packet(len, tag, calc, mode, pos, t0);
            wait_idle(400);
        end
        rdy_random = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_out_ready = 1'b1;
        check_counts("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gcm_rx_tag_checker.md
Name: gcm_rx_tag_checker

Overview:
- Receive-side counterpart of the GCM encrypt packet API: accepts the encrypted packet stream (payload words followed by one trailing 128-bit tag word), stores it, and checks the received tag against the tag computed by the decrypt/GHASH core.
- Store-and-forward. A packet is released downstream only on a tag match; otherwise it is dropped whole.
- Sits between the link-side stream and the host-side consumer.

Parameters:
- DATA_W, 128, payload/tag word width
- META_W, 289, width of per-packet bypass metadata captured from the first word
- DEPTH, 64, maximum payload words per packet (power of 2)
- TIMEOUT, 1024, maximum cycles spent in WAIT_TAG before the packet is dropped

Ports:
- clk  in  1  clock
- reset  in  1  reset
- i_valid  in  1  input word valid
- o_in_ready  out  1  input ready; a word transfers when i_valid & o_in_ready
- i_new  in  1  first word of packet
- i_last  in  1  tag word (last word of packet)
- i_data  in  DATA_W  payload or tag word
- i_meta  in  META_W  bypass metadata, valid with i_new
- i_tag_valid  in  1  one-cycle pulse: i_calc_tag valid
- i_calc_tag  in  DATA_W  tag computed by the decrypt core
- o_valid  out  1  output word valid
- i_out_ready  in  1  downstream ready
- o_new  out  1  first released word
- o_last  out  1  last released payload word
- o_data  out  DATA_W  released payload word
- o_meta  out  META_W  captured metadata, stable through RELEASE
- o_pass  out  1  one-cycle pulse: tag matched
- o_drop  out  1  one-cycle pulse: packet dropped

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk, all logic on its rising edge.
- Reset values: all outputs 0, state IDLE, word count 0, tag-pending flag 0. o_in_ready is 0 while reset is high.
- States: IDLE, COLLECT, DISCARD, WAIT_TAG, RELEASE.
- o_in_ready is 1 in IDLE, COLLECT and DISCARD; 0 in WAIT_TAG and RELEASE.
- IDLE:
  - accepted word with i_new & !i_last: write i_data to buffer[0], capture i_meta, count=1, go to COLLECT
  - i_new & i_last on the same beat: malformed; pulse o_drop, stay in IDLE
  - accepted word without i_new: silently discarded
- COLLECT:
  - accepted word with !i_last: if count==DEPTH, go to DISCARD (no write); else write buffer[count], count+1
  - accepted word with i_last: store it in tag_reg (not in buffer), go to WAIT_TAG
  - accepted word with i_new: pulse o_drop for the current packet, restart with this word exactly as IDLE would (including the malformed check)
- DISCARD: consume words until i_last is accepted, then pulse o_drop, count=0, go to IDLE. i_new seen here is treated as in COLLECT.
- Tag capture:
  - i_tag_valid in COLLECT or WAIT_TAG latches i_calc_tag into calc_reg and sets the pending flag.
  - i_tag_valid is ignored in IDLE, DISCARD and RELEASE.
  - A second pulse overwrites calc_reg.
- WAIT_TAG:
  - Compares when pending or i_tag_valid is set; i_calc_tag is used directly if it arrives this cycle.
  - Equal: pulse o_pass, go to RELEASE.
  - Unequal: pulse o_drop, go to IDLE.
  - Timeout counter starts at 0 on entry. At TIMEOUT-1 with no tag: pulse o_drop, go to IDLE.
  - Pending flag is cleared on leaving WAIT_TAG.
- RELEASE:
  - o_valid rises the cycle after o_pass.
  - Words are read in order 0..count-1. o_new is set on word 0; o_last on word count-1 (both on the same beat when count==1).
  - o_data, o_new and o_last are held stable while o_valid & !i_out_ready.
  - After the last word handshakes: o_valid=0, count=0, go to IDLE.
- Throughput: one word per cycle in both directions with no bubbles. Buffer read is registered and prefetched so continuous ready yields back-to-back words.
- Reset mid-operation: immediate return to the reset state; buffer contents are don't-care; no o_pass or o_drop is emitted.
- Tag compare is a full DATA_W equality, no masking.

Decomposition:
- Shared package gcm_rx_pkg: state enum (IDLE, COLLECT, DISCARD, WAIT_TAG, RELEASE) and default DATA_W/META_W constants.
- One sub-module, gcm_rx_buffer:
  - simple dual-port memory of DEPTH x DATA_W
  - synchronous write and registered read, with read-enable for the prefetch
- FSM, counters and the compare stay in the top module.

Test Plan:
- 3 payload words A,B,C + tag T; i_tag_valid with T during COLLECT -> o_pass one cycle after the tag word; A(o_new),B,C(o_last) back-to-back with i_out_ready=1; o_meta equals the captured i_meta.
- Same packet; i_calc_tag = T^1 arrives 5 cycles into WAIT_TAG -> o_drop pulse, no o_valid, o_in_ready=1 the next cycle.
- DEPTH+2 payload words then tag -> DISCARD; single o_drop after the tag word; no output; the next good packet passes normally.
- No i_tag_valid after the tag word -> o_drop exactly TIMEOUT cycles after entering WAIT_TAG.
- 2-word packet, pass, i_out_ready toggling 1,0,0,1 -> o_data/o_new held stable across the stall; exactly 2 handshakes.
- i_new arriving mid-COLLECT -> o_drop for the old packet; the new packet collects from its first word and passes; reset asserted during RELEASE -> o_valid=0 the next cycle and no pulses.
